// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request/acknowledge transaction per access,
// with load extension, store lane formatting, misalignment detection and bus timeout.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic [31:0] mem_read_data,
   output logic        lsu_stall,
   output logic        done,
   output logic        misaligned,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {IDLE, WAIT_ACK, RESP} state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic               is_load, is_load_next;
   logic [2:0]         funct3_q, funct3_next;
   logic [1:0]         addr_lo, addr_lo_next;
   logic [31:0]        mem_read_data_next, bus_addr_next, bus_wdata_next;
   logic [3:0]         bus_be_next;
   logic               bus_req_next, bus_we_next, done_next, misaligned_next, bus_err_next;

   logic               aligned;
   logic [31:0]        st_wdata;
   logic [3:0]         st_be;
   logic [7:0]         ld_byte;
   logic [15:0]        ld_half;
   logic [31:0]        ld_value;

   // Size decode: 00 byte, 01 half, anything else behaves as a word access
   always_comb begin
      aligned  = 1'b1;
      st_wdata = store_data;
      st_be    = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            st_wdata = {4{store_data[7:0]}};
            st_be    = 4'b0001 << addr[1:0];
         end
         2'b01: begin
            aligned  = ~addr[0];
            st_wdata = {2{store_data[15:0]}};
            st_be    = addr[1] ? 4'b1100 : 4'b0011;
         end
         default: aligned = (addr[1:0] == 2'b00);
      endcase
   end

   // Lane select and extension of the returned read word
   always_comb begin
      case (addr_lo)
         2'd0:    ld_byte = bus_rdata[7:0];
         2'd1:    ld_byte = bus_rdata[15:8];
         2'd2:    ld_byte = bus_rdata[23:16];
         default: ld_byte = bus_rdata[31:24];
      endcase
      ld_half = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (funct3_q[1:0])
         2'b00:   ld_value = funct3_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   ld_value = funct3_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_value = bus_rdata;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_next         = state;
      cnt_next           = cnt;
      is_load_next       = is_load;
      funct3_next        = funct3_q;
      addr_lo_next       = addr_lo;
      mem_read_data_next = mem_read_data;
      bus_addr_next      = bus_addr;
      bus_wdata_next     = bus_wdata;
      bus_be_next        = bus_be;
      bus_req_next       = bus_req;
      bus_we_next        = bus_we;
      done_next          = 1'b0;
      misaligned_next    = 1'b0;
      bus_err_next       = 1'b0;
      case (state)
         IDLE: begin
            if (mem_read || mem_write) begin
               if (!aligned) begin
                  state_next      = RESP;
                  done_next       = 1'b1;
                  misaligned_next = 1'b1;
               end else begin
                  state_next     = WAIT_ACK;
                  bus_req_next   = 1'b1;
                  bus_we_next    = ~mem_read;
                  bus_addr_next  = {addr[31:2], 2'b00};
                  bus_wdata_next = st_wdata;
                  bus_be_next    = mem_read ? 4'b1111 : st_be;
                  cnt_next       = '0;
                  is_load_next   = mem_read;
                  funct3_next    = funct3;
                  addr_lo_next   = addr[1:0];
               end
            end
         end
         WAIT_ACK: begin
            if (bus_ack) begin
               state_next   = RESP;
               bus_req_next = 1'b0;
               done_next    = 1'b1;
               if (is_load) mem_read_data_next = ld_value;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_next   = RESP;
               bus_req_next = 1'b0;
               done_next    = 1'b1;
               bus_err_next = 1'b1;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         is_load       <= 1'b0;
         funct3_q      <= '0;
         addr_lo       <= '0;
         mem_read_data <= '0;
         bus_addr      <= '0;
         bus_wdata     <= '0;
         bus_be        <= '0;
         bus_req       <= 1'b0;
         bus_we        <= 1'b0;
         done          <= 1'b0;
         misaligned    <= 1'b0;
         bus_err       <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         is_load       <= is_load_next;
         funct3_q      <= funct3_next;
         addr_lo       <= addr_lo_next;
         mem_read_data <= mem_read_data_next;
         bus_addr      <= bus_addr_next;
         bus_wdata     <= bus_wdata_next;
         bus_be        <= bus_be_next;
         bus_req       <= bus_req_next;
         bus_we        <= bus_we_next;
         done          <= done_next;
         misaligned    <= misaligned_next;
         bus_err       <= bus_err_next;
      end
   end

   // Stall releases in RESP so the pipeline advances on the completion cycle
   assign lsu_stall = ((state == IDLE) && (mem_read || mem_write)) || (state == WAIT_ACK);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus queues expected bus requests and
// responses; a negedge monitor pops and compares them as the DUT presents them.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] addr = '0, store_data = '0;
   logic [31:0] mem_read_data;
   logic        lsu_stall, done, misaligned, bus_err, bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .store_data(store_data),
      .mem_read_data(mem_read_data), .lsu_stall(lsu_stall), .done(done),
      .misaligned(misaligned), .bus_err(bus_err), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] mrd;
      logic        mis;
      logic        err;
      int          issue;
      int          lat;
      int          stall;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   resp_t rq[$];
   bus_t  bq[$];
   int    checks = 0, failures = 0;
   int    cyc = 0;
   int    resp_seen = 0;
   int    stall_cnt = 0;
   logic  prev_req = 1'b0;
   int    ack_delay = 0;
   logic  ack_en = 1'b1;
   logic  force_ack = 1'b0;
   int    wcnt = 0;

   always @(posedge clk) cyc++;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Bus slave: ack after ack_delay WAIT_ACK cycles, or a one-shot forced ack
   always @(posedge clk) begin
      #2;
      if (bus_ack) begin
         bus_ack = 1'b0;
         wcnt    = 0;
      end else if (force_ack) begin
         bus_ack   = 1'b1;
         force_ack = 1'b0;
      end else if (bus_req && ack_en) begin
         if (wcnt == ack_delay) bus_ack = 1'b1;
         else wcnt++;
      end else begin
         wcnt = 0;
      end
   end

   // Monitor: compares bus requests at their rising edge and responses at done
   always @(negedge clk) begin
      bus_t  b;
      resp_t r;
      if (rst_n) begin
         if (lsu_stall) stall_cnt++;
         if (bus_req && !prev_req) begin
            if (bq.size() == 0) begin
               chk("unexpected_bus_req", 32'(bus_req), 32'd0);
            end else begin
               b = bq.pop_front();
               chk("bus_addr", bus_addr, b.addr);
               chk("bus_we", 32'(bus_we), 32'(b.we));
               chk("bus_be", 32'(bus_be), 32'(b.be));
               if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
            end
         end
         if (done) begin
            if (rq.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               r = rq.pop_front();
               chk("mem_read_data", mem_read_data, r.mrd);
               chk("misaligned", 32'(misaligned), 32'(r.mis));
               chk("bus_err", 32'(bus_err), 32'(r.err));
               chk("latency", 32'(cyc - r.issue), 32'(r.lat));
               chk("stall_cycles", 32'(stall_cnt), 32'(r.stall));
            end
            resp_seen++;
         end else if (misaligned || bus_err) begin
            chk("flag_without_done", {30'd0, misaligned, bus_err}, 32'd0);
         end
      end
      prev_req = bus_req;
   end

   // Issue one access (called just after a rising edge) and wait for its response
   task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd,
                      input logic mis, input logic err, input logic [31:0] exp_mrd,
                      input int lat, input int stall,
                      input logic has_bus, input logic [31:0] b_addr, input logic b_we,
                      input logic [3:0] b_be, input logic [31:0] b_wdata);
      resp_t r;
      bus_t  b;
      int    seen0;
      seen0     = resp_seen;
      stall_cnt = 0;
      r.mrd = exp_mrd; r.mis = mis; r.err = err; r.issue = cyc; r.lat = lat; r.stall = stall;
      rq.push_back(r);
      if (has_bus) begin
         b.addr = b_addr; b.we = b_we; b.be = b_be; b.wdata = b_wdata;
         bq.push_back(b);
      end
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      for (int i = 0; i < 30 && resp_seen == seen0; i++) begin
         @(posedge clk); #1;
      end
      chk("response_arrived", 32'(resp_seen != seen0), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      @(posedge clk); #1;
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_flags", {30'd0, misaligned, bus_err}, 32'd0);
      chk("rst_mem_read_data", mem_read_data, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      chk("rst_bus_be_we", {27'd0, bus_we, bus_be}, 32'd0);
      chk("rst_stall", 32'(lsu_stall), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Loads with first-cycle ack
      bus_rdata = 32'hDEADBEEF; ack_delay = 0;
      txn(1, 0, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF, 2, 2, 1, 32'h100, 0, 4'hF, 0);
      bus_rdata = 32'h80AA55CC;
      txn(1, 0, 3'b000, 32'h103, 0, 0, 0, 32'hFFFFFF80, 2, 2, 1, 32'h100, 0, 4'hF, 0);
      txn(1, 0, 3'b100, 32'h103, 0, 0, 0, 32'h00000080, 2, 2, 1, 32'h100, 0, 4'hF, 0);
      txn(1, 0, 3'b001, 32'h102, 0, 0, 0, 32'hFFFF80AA, 2, 2, 1, 32'h100, 0, 4'hF, 0);
      ack_delay = 2;
      txn(1, 0, 3'b101, 32'h100, 0, 0, 0, 32'h000055CC, 4, 4, 1, 32'h100, 0, 4'hF, 0);

      // Stores leave mem_read_data untouched
      ack_delay = 0;
      txn(0, 1, 3'b000, 32'h201, 32'h12345678, 0, 0, 32'h000055CC, 2, 2, 1, 32'h200, 1, 4'b0010, 32'h78787878);
      txn(0, 1, 3'b001, 32'h202, 32'h12345678, 0, 0, 32'h000055CC, 2, 2, 1, 32'h200, 1, 4'b1100, 32'h56785678);
      ack_delay = 1;
      txn(0, 1, 3'b010, 32'h300, 32'h12345678, 0, 0, 32'h000055CC, 3, 3, 1, 32'h300, 1, 4'hF, 32'h12345678);

      // Misaligned accesses never reach the bus
      txn(1, 0, 3'b010, 32'h102, 0, 1, 0, 32'h000055CC, 1, 1, 0, 0, 0, 0, 0);
      txn(0, 1, 3'b001, 32'h201, 32'hAAAA5555, 1, 0, 32'h000055CC, 1, 1, 0, 0, 0, 0, 0);
      txn(1, 0, 3'b011, 32'h10A, 0, 1, 0, 32'h000055CC, 1, 1, 0, 0, 0, 0, 0);

      // Read wins over simultaneous write
      ack_delay = 0; bus_rdata = 32'h0BADF00D;
      txn(1, 1, 3'b010, 32'h104, 32'hFFFFFFFF, 0, 0, 32'h0BADF00D, 2, 2, 1, 32'h104, 0, 4'hF, 0);

      // Timeout after four WAIT_ACK cycles, then a stray ack in IDLE
      ack_en = 1'b0;
      txn(1, 0, 3'b010, 32'h108, 0, 0, 1, 32'h0BADF00D, 5, 5, 1, 32'h108, 0, 4'hF, 0);
      bus_rdata = 32'h11111111;
      force_ack = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("late_ack_ignored", mem_read_data, 32'h0BADF00D);

      // Asynchronous reset in WAIT_ACK abandons the access
      begin
         bus_t b;
         b.addr = 32'h110; b.we = 1'b0; b.be = 4'hF; b.wdata = '0;
         bq.push_back(b);
      end
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h110;
      @(posedge clk); #1;
      mem_read = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset_bus_req", 32'(bus_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_bus_req", 32'(bus_req), 32'd0);
      chk("async_rst_mem_read_data", mem_read_data, 32'd0);
      chk("async_rst_stall", 32'(lsu_stall), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; ack_en = 1'b1; ack_delay = 0; bus_rdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      txn(1, 0, 3'b010, 32'h10C, 0, 0, 0, 32'hCAFEF00D, 2, 2, 1, 32'h10C, 0, 4'hF, 0);

      chk("scoreboard_drained", 32'(rq.size() + bq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
